yakbd_keydecode: RTL and testbench
==================================

# yakbd_keydecode

Stateful PS/2 set-2 scancode decoder for the yakbd keyboard driver. It consumes a raw byte stream from the PS/2 receiver and tracks break (F0) and extended (E0) prefixes. It also tracks the Shift, Ctrl and Caps Lock state, and pushes decoded ASCII characters into a parametrised FIFO. The CPU/console side drains that FIFO through a valid/ready handshake. It replaces per-byte combinational translation, which had no prefix tracking and no buffering.

## Interface
Parameters:
- FIFO_DEPTH, 8: character FIFO entries; power of two, ≥2.
- CTRL_MODE, 1: 0 = Ctrl+C yields 0x14, all other Ctrl chords translate normally; 1 = Ctrl+letter yields uppercase & 0x1F.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- scan_valid  in  1  one-cycle strobe; scan_data holds a received byte.
- scan_data  in  8  PS/2 byte.
- ascii_valid  out  1  FIFO non-empty.
- ascii_data  out  8  FIFO head, first-word fall-through.
- ascii_ready  in  1  consumer pops the head when ascii_valid is also high.
- shift_o, ctrl_o, caps_o  out  1 each  current modifier state.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  one-cycle pulse when a character is dropped.

## Operation
- Parser FSM states: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: on E0 go to EXT; on F0 go to BRK; on any other byte, process it as a make code and stay in IDLE.
  - EXT: on F0 go to EXT_BRK; on any other byte, process it as an extended make code and return to IDLE.
  - BRK and EXT_BRK: the next byte is processed as a break code (normal or extended), then return to IDLE.
  - A repeated E0 in EXT, or F0 in BRK, is absorbed and the state is unchanged.
- Modifier handling:
  - Shift: 0x12 and 0x59 are tracked as separate left/right bits; shift_o is their OR. Make sets a bit, break clears it.
  - Ctrl: 0x14 and E0 0x14 are tracked as separate bits; ctrl_o is their OR.
  - Caps Lock (0x58): caps_o toggles on a make only when the internal caps_held flag is 0. The make sets caps_held and the break clears it, so typematic repeats do not toggle caps_o.
- Character translation applies on make codes only:
  - Letters: uppercase when shift XOR caps.
  - Digits and symbols: shift selects the US-layout shifted glyph; caps has no effect.
  - Fixed codes: space 0x29 → 0x20; backspace 0x66 → 0x08; enter 0x5A or E0 0x5A → 0x0A; E0 0x4A → 0x2F.
  - Arrows: E0 0x75/0x72/0x6B/0x74 → 0x01/0x02/0x03/0x04 (up/down/left/right).
  - Non-E0 keypad codes, unmapped codes and all break codes push nothing. 0x00 is never pushed.
- Ctrl chords take priority over the shift/caps result:
  - CTRL_MODE=0: Ctrl+C (0x21) → 0x14.
  - CTRL_MODE=1: Ctrl+letter → uppercase letter & 0x1F.
  - Ctrl with a non-letter key translates normally.
- Typematic repeats (repeated make codes) each push a character.
- FIFO:
  - A push when full and not popping in the same cycle is dropped, and overflow pulses.
  - Push and pop in the same cycle are both accepted when full; count is unchanged.
  - Push and pop in the same cycle when empty: the pushed character appears at the head next cycle; the pop is ignored because ascii_valid was 0.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset:
  - FSM returns to IDLE; FIFO empties; all modifier bits and caps_held clear.
  - Outputs are all 0, including ascii_data.
  - Reset mid-sequence (e.g. between E0 and the key byte) discards the pending prefix.

## Timing
- A scan byte is consumed on the clk edge where scan_valid=1; back-to-back bytes on consecutive cycles are supported.
- A decoded character becomes visible (ascii_valid=1, data at head) on the cycle after its scan byte is consumed, provided the FIFO was empty.
- shift_o, ctrl_o and caps_o update on the cycle after the modifier byte.
- A character's case uses the modifier state registered before the character's own byte.
- A pop takes effect at the edge; the next entry is presented the following cycle.
- overflow is high for exactly the cycle after the dropped scan byte.

## Structure
- Package yakbd_pkg holds:
  - Scancode constants: SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_CAPS.
  - ASCII constants: ASC_UP..ASC_RIGHT, ASC_BS, ASC_LF.
  - The FSM state encoding.
- Sub-module yakbd_scan_lut is purely combinational. Inputs: code, ext, shift, caps. Outputs: ascii, is_letter, hit.
- The FSM, modifier registers, ctrl remap and FIFO live in yakbd_keydecode.

## Test plan
- Reset, then bytes 1C, F0 1C → exactly one 0x61 ('a'); ascii_valid falls after a single pop; fifo_count returns to 0.
- 12, 1C, F0 1C, F0 12, 1C → FIFO holds 0x41, then 0x61; shift_o=1 only between the 12 and the F0 12.
- 58 58 58 F0 58 (typematic), then 1C, 16 → caps_o=1 after the first byte only, then 0x41, 0x31; a second 58 F0 58 returns caps_o to 0.
- E0 75, E0 F0 75, 75, E0 5A → 0x01, then 0x0A; non-E0 75 pushes nothing.
- Ctrl+C as 14 21: CTRL_MODE=0 → 0x14; CTRL_MODE=1 → 0x03. Ctrl+1 as 14 16 → 0x31 in both modes.
- FIFO_DEPTH=4, ascii_ready=0, six presses of 1C → count=4, two overflow pulses. Then ready=1 with a 1C on the same cycle → count stays 4, no overflow; drained order is 0x61 ×5.

Source files
------------

// File: rtl/yakbd_pkg.sv
// Shared scancode/ASCII constants and parser state encoding for the yakbd
// PS/2 set-2 keyboard decoder.
package yakbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] ASC_UP    = 8'h01;
  localparam logic [7:0] ASC_DOWN  = 8'h02;
  localparam logic [7:0] ASC_LEFT  = 8'h03;
  localparam logic [7:0] ASC_RIGHT = 8'h04;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

endpackage

// File: rtl/yakbd_scan_lut.sv
// Combinational set-2 make-code to ASCII translation (US layout) with
// shift/caps applied; ctrl chords are handled by the caller.
module yakbd_scan_lut
  import yakbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii,
  output logic       is_letter,
  output logic       hit
);

  logic [7:0] letter_lc;
  logic [7:0] sym_base;
  logic [7:0] sym_shift;

  always_comb begin
    letter_lc = 8'h00;
    case (code)
      8'h1C: letter_lc = 8'h61;  8'h32: letter_lc = 8'h62;
      8'h21: letter_lc = 8'h63;  8'h23: letter_lc = 8'h64;
      8'h24: letter_lc = 8'h65;  8'h2B: letter_lc = 8'h66;
      8'h34: letter_lc = 8'h67;  8'h33: letter_lc = 8'h68;
      8'h43: letter_lc = 8'h69;  8'h3B: letter_lc = 8'h6A;
      8'h42: letter_lc = 8'h6B;  8'h4B: letter_lc = 8'h6C;
      8'h3A: letter_lc = 8'h6D;  8'h31: letter_lc = 8'h6E;
      8'h44: letter_lc = 8'h6F;  8'h4D: letter_lc = 8'h70;
      8'h15: letter_lc = 8'h71;  8'h2D: letter_lc = 8'h72;
      8'h1B: letter_lc = 8'h73;  8'h2C: letter_lc = 8'h74;
      8'h3C: letter_lc = 8'h75;  8'h2A: letter_lc = 8'h76;
      8'h1D: letter_lc = 8'h77;  8'h22: letter_lc = 8'h78;
      8'h35: letter_lc = 8'h79;  8'h1A: letter_lc = 8'h7A;
      default: letter_lc = 8'h00;
    endcase
  end

  // Digits and punctuation: {unshifted, shifted}; caps lock does not apply.
  always_comb begin
    sym_base  = 8'h00;
    sym_shift = 8'h00;
    case (code)
      8'h16: {sym_base, sym_shift} = {8'h31, 8'h21};
      8'h1E: {sym_base, sym_shift} = {8'h32, 8'h40};
      8'h26: {sym_base, sym_shift} = {8'h33, 8'h23};
      8'h25: {sym_base, sym_shift} = {8'h34, 8'h24};
      8'h2E: {sym_base, sym_shift} = {8'h35, 8'h25};
      8'h36: {sym_base, sym_shift} = {8'h36, 8'h5E};
      8'h3D: {sym_base, sym_shift} = {8'h37, 8'h26};
      8'h3E: {sym_base, sym_shift} = {8'h38, 8'h2A};
      8'h46: {sym_base, sym_shift} = {8'h39, 8'h28};
      8'h45: {sym_base, sym_shift} = {8'h30, 8'h29};
      8'h0E: {sym_base, sym_shift} = {8'h60, 8'h7E};
      8'h4E: {sym_base, sym_shift} = {8'h2D, 8'h5F};
      8'h55: {sym_base, sym_shift} = {8'h3D, 8'h2B};
      8'h54: {sym_base, sym_shift} = {8'h5B, 8'h7B};
      8'h5B: {sym_base, sym_shift} = {8'h5D, 8'h7D};
      8'h5D: {sym_base, sym_shift} = {8'h5C, 8'h7C};
      8'h4C: {sym_base, sym_shift} = {8'h3B, 8'h3A};
      8'h52: {sym_base, sym_shift} = {8'h27, 8'h22};
      8'h41: {sym_base, sym_shift} = {8'h2C, 8'h3C};
      8'h49: {sym_base, sym_shift} = {8'h2E, 8'h3E};
      8'h4A: {sym_base, sym_shift} = {8'h2F, 8'h3F};
      8'h29: {sym_base, sym_shift} = {8'h20, 8'h20};
      8'h66: {sym_base, sym_shift} = {ASC_BS, ASC_BS};
      8'h5A: {sym_base, sym_shift} = {ASC_LF, ASC_LF};
      default: {sym_base, sym_shift} = {8'h00, 8'h00};
    endcase
  end

  always_comb begin
    ascii     = 8'h00;
    is_letter = 1'b0;
    hit       = 1'b0;
    if (ext) begin
      hit = 1'b1;
      case (code)
        8'h75:   ascii = ASC_UP;
        8'h72:   ascii = ASC_DOWN;
        8'h6B:   ascii = ASC_LEFT;
        8'h74:   ascii = ASC_RIGHT;
        8'h5A:   ascii = ASC_LF;
        8'h4A:   ascii = 8'h2F;
        default: hit = 1'b0;
      endcase
    end else if (letter_lc != 8'h00) begin
      hit       = 1'b1;
      is_letter = 1'b1;
      ascii     = (shift ^ caps) ? (letter_lc & 8'hDF) : letter_lc;
    end else if (sym_base != 8'h00) begin
      hit   = 1'b1;
      ascii = shift ? sym_shift : sym_base;
    end
  end

endmodule

// File: rtl/yakbd_keydecode.sv
// PS/2 set-2 byte stream decoder: prefix FSM, modifier tracking, ctrl remap
// and a first-word fall-through character FIFO drained by valid/ready.
module yakbd_keydecode
  import yakbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CTRL_MODE  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scan_valid,
  input  logic [7:0]                    scan_data,
  output logic                          ascii_valid,
  output logic [7:0]                    ascii_data,
  input  logic                          ascii_ready,
  output logic                          shift_o,
  output logic                          ctrl_o,
  output logic                          caps_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // Handshake: a character transfers on a clk edge where ascii_valid and
  // ascii_ready are both high; ascii_data is stable while valid waits.

  state_t state;
  logic   l_shift, r_shift, l_ctrl, r_ctrl, caps, caps_held;

  logic       key_valid, key_ext, key_brk;
  state_t     state_next;
  logic [7:0] lut_ascii, ch;
  logic       lut_letter, lut_hit;
  logic       push, pop, full, accept;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // Prefix bytes move the parser; every other byte is a key event whose
  // make/break and extended flags come from the current state.
  always_comb begin
    key_valid  = 1'b0;
    key_ext    = 1'b0;
    key_brk    = 1'b0;
    state_next = state;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_data == SC_EXT)        state_next = ST_EXT;
          else if (scan_data == SC_BREAK) state_next = ST_BRK;
          else                            key_valid  = 1'b1;
        end
        ST_EXT: begin
          key_ext = 1'b1;
          if (scan_data == SC_BREAK)      state_next = ST_EXT_BRK;
          else if (scan_data != SC_EXT) begin
            key_valid  = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          key_brk = 1'b1;
          if (scan_data != SC_BREAK) begin
            key_valid  = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: begin
          key_ext    = 1'b1;
          key_brk    = 1'b1;
          key_valid  = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  yakbd_scan_lut u_lut (
    .code      (scan_data),
    .ext       (key_ext),
    .shift     (shift_o),
    .caps      (caps_o),
    .ascii     (lut_ascii),
    .is_letter (lut_letter),
    .hit       (lut_hit)
  );

  always_comb begin
    ch = lut_ascii;
    if (ctrl_o && CTRL_MODE == 1 && lut_letter)
      ch = lut_ascii & 8'h1F;
    else if (ctrl_o && CTRL_MODE == 0 && !key_ext && scan_data == 8'h21)
      ch = 8'h14;
  end

  assign push   = key_valid && !key_brk && lut_hit && (ch != 8'h00);
  assign pop    = ascii_ready && (count != '0);
  assign full   = (count == FULL_CNT);
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      l_shift   <= 1'b0;
      r_shift   <= 1'b0;
      l_ctrl    <= 1'b0;
      r_ctrl    <= 1'b0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      state    <= state_next;
      overflow <= push && !accept;
      if (key_valid) begin
        if (!key_ext && scan_data == SC_LSHIFT) l_shift <= !key_brk;
        if (!key_ext && scan_data == SC_RSHIFT) r_shift <= !key_brk;
        if (!key_ext && scan_data == SC_CTRL)   l_ctrl  <= !key_brk;
        if (key_ext && scan_data == SC_CTRL)    r_ctrl  <= !key_brk;
        // Typematic caps repeats keep caps_held set, so only the first toggles.
        if (!key_ext && scan_data == SC_CAPS) begin
          if (key_brk) begin
            caps_held <= 1'b0;
          end else begin
            caps_held <= 1'b1;
            if (!caps_held) caps <= !caps;
          end
        end
      end
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (!accept && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= ch;
  end

  assign shift_o     = l_shift | r_shift;
  assign ctrl_o      = l_ctrl | r_ctrl;
  assign caps_o      = caps;
  assign fifo_count  = count;
  assign ascii_valid = (count != '0);
  assign ascii_data  = (count != '0) ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_yakbd_keydecode.sv
// Directed bench for yakbd_keydecode: three instances (default, CTRL_MODE=0,
// FIFO_DEPTH=4) share one scan stream and reset; each has its own ready.
module tb_yakbd_keydecode;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_data = 8'h00;
  logic       rdy = 1'b0, rdy0 = 1'b0, rdy4 = 1'b0;

  logic       av, sh, ct, cp, ov;
  logic [7:0] ad;
  logic [3:0] cnt;
  logic       av0, sh0, ct0, cp0, ov0;
  logic [7:0] ad0;
  logic [3:0] cnt0;
  logic       av4, sh4, ct4, cp4, ov4;
  logic [7:0] ad4;
  logic [2:0] cnt4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  yakbd_keydecode #(.FIFO_DEPTH(8), .CTRL_MODE(1)) dut (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_data(scan_data),
    .ascii_valid(av), .ascii_data(ad), .ascii_ready(rdy),
    .shift_o(sh), .ctrl_o(ct), .caps_o(cp), .fifo_count(cnt), .overflow(ov)
  );

  yakbd_keydecode #(.FIFO_DEPTH(8), .CTRL_MODE(0)) dut_m0 (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_data(scan_data),
    .ascii_valid(av0), .ascii_data(ad0), .ascii_ready(rdy0),
    .shift_o(sh0), .ctrl_o(ct0), .caps_o(cp0), .fifo_count(cnt0), .overflow(ov0)
  );

  yakbd_keydecode #(.FIFO_DEPTH(4), .CTRL_MODE(1)) dut_d4 (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_data(scan_data),
    .ascii_valid(av4), .ascii_data(ad4), .ascii_ready(rdy4),
    .shift_o(sh4), .ctrl_o(ct4), .caps_o(cp4), .fifo_count(cnt4), .overflow(ov4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rdy = 1'b0; rdy0 = 1'b0; rdy4 = 1'b0; scan_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Byte is consumed at the next posedge; returns on the following negedge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_valid = 1'b1;
    scan_data  = b;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic pop1();
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic pop4();
    @(negedge clk);
    rdy4 = 1'b1;
    @(negedge clk);
    rdy4 = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_valid", av, 0);
    check("rst_data", ad, 0);
    check("rst_count", cnt, 0);
    check("rst_mods", {sh, ct, cp}, 0);
    check("rst_ovf", ov, 0);

    // Plain 'a' with its break code
    send(8'h1C);
    check("a_valid", av, 1);
    check("a_data", ad, 8'h61);
    send(8'hF0); send(8'h1C);
    check("a_count", cnt, 1);
    pop1();
    check("a_pop_valid", av, 0);
    check("a_pop_count", cnt, 0);

    // Shift held around one 'a'
    send(8'h12);
    check("shift_on", sh, 1);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0);
    check("shift_held", sh, 1);
    send(8'h12);
    check("shift_off", sh, 0);
    send(8'h1C);
    check("shift_count", cnt, 2);
    check("shift_head0", ad, 8'h41);
    pop1();
    check("shift_head1", ad, 8'h61);
    pop1();

    // Right shift is tracked independently
    send(8'h59); send(8'h16);
    check("rshift_bang", ad, 8'h21);
    send(8'hF0); send(8'h59);
    check("rshift_off", sh, 0);
    pop1();

    // Caps lock with typematic repeats
    send(8'h58);
    check("caps_first", cp, 1);
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    check("caps_repeat", cp, 1);
    send(8'h1C); send(8'h16);
    check("caps_letter", ad, 8'h41);
    pop1();
    check("caps_digit", ad, 8'h31);
    pop1();
    send(8'h58); send(8'hF0); send(8'h58);
    check("caps_off", cp, 0);

    // Extended keys
    send(8'hE0); send(8'h75);
    check("ext_up", ad, 8'h01);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h75);
    check("kp8_nopush", cnt, 1);
    send(8'hE0); send(8'h5A);
    check("ext_enter_cnt", cnt, 2);
    pop1();
    check("ext_enter", ad, 8'h0A);
    pop1();
    send(8'hE0); send(8'hE0); send(8'h4A);
    check("ext_slash", ad, 8'h2F);
    pop1();
    send(8'h29);
    check("space", ad, 8'h20);
    pop1();

    // Ctrl chords in both modes
    do_reset();
    send(8'h14);
    check("ctrl_on", ct, 1);
    send(8'h21);
    check("ctrlc_mode1", ad, 8'h03);
    check("ctrlc_mode0", ad0, 8'h14);
    do_reset();
    check("ctrl_rst", ct, 0);
    send(8'h14); send(8'h16);
    check("ctrl1_mode1", ad, 8'h31);
    check("ctrl1_mode0", ad0, 8'h31);
    send(8'hE0); send(8'hF0); send(8'h14);
    check("rctrl_brk_keeps_l", ct, 1);

    // Reset between E0 and the key byte drops the prefix
    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h75);
    check("rst_prefix", cnt, 0);

    // Push into empty FIFO with ready already high
    @(negedge clk);
    rdy = 1'b1; scan_valid = 1'b1; scan_data = 8'h1C;
    @(negedge clk);
    rdy = 1'b0; scan_valid = 1'b0;
    check("empty_pushpop_cnt", cnt, 1);
    check("empty_pushpop_data", ad, 8'h61);

    // Overflow on the depth-4 instance
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(8'h1C);
      check($sformatf("ovf_press%0d", i), ov4, (i >= 4) ? 1 : 0);
    end
    check("ovf_full", cnt4, 4);
    @(negedge clk);
    rdy4 = 1'b1; scan_valid = 1'b1; scan_data = 8'h1C;
    @(negedge clk);
    rdy4 = 1'b0; scan_valid = 1'b0;
    check("full_pushpop_cnt", cnt4, 4);
    check("full_pushpop_ovf", ov4, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), ad4, 8'h61);
      pop4();
    end
    check("drain_empty", cnt4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
